pipe_stage_fifo: RTL and testbench

PIPE_STAGE_FIFO -- requirements
Module: pipe_stage_fifo

---
 rtl/pipe_stage_fifo.sv | 68 ++++++
 tb/tb_pipe_stage_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_fifo.sv
// Registered-output ready/valid FIFO stage with DEPTH entries; no combinational path between sides.
// Optional flush is compiled in with PIPE_STAGE_FLUSH_EN; otherwise the flush port is ignored.
module pipe_stage_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  count
);

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic                         push;
    logic                         pop;
    logic                         do_flush;

`ifdef PIPE_STAGE_FLUSH_EN
    assign do_flush = flush;
`else
    localparam logic FLUSH_EN = 1'b0;
    assign do_flush = flush & FLUSH_EN;
`endif

    // Ready/valid derive only from occupancy, so neither side sees the other combinationally.
    assign s_ready = (count != CNT_W'(DEPTH));
    assign m_valid = (count != '0);
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    assign m_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (do_flush) begin
            // Storage is left as-is; zero occupancy already hides it.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: DEPTH=2 and DEPTH=4 instances checked against a queue scoreboard.
module tb_pipe_stage_fifo;

`ifdef PIPE_STAGE_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush2 = 0, s_valid2 = 0, m_ready2 = 0, s_ready2, m_valid2;
    logic [31:0] s_data2 = '0, m_data2;
    logic [1:0]  count2;
    logic        flush4 = 0, s_valid4 = 0, m_ready4 = 0, s_ready4, m_valid4;
    logic [31:0] s_data4 = '0, m_data4;
    logic [2:0]  count4;

    always #5 clk = ~clk;

    pipe_stage_fifo #(.DATA_W(32), .DEPTH(2)) d2 (
        .clk(clk), .rst(rst), .flush(flush2),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .count(count2));

    pipe_stage_fifo #(.DATA_W(32), .DEPTH(4)) d4 (
        .clk(clk), .rst(rst), .flush(flush4),
        .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
        .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4), .count(count4));

    int          checks = 0;
    int          errors = 0;
    int          pops2  = 0;
    logic [31:0] q2[$];
    logic [31:0] q4[$];
    logic [31:0] out2[$];

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        mr;
        int          exp_count;
        logic [31:0] exp_head;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, score handshakes before the edge, check state #1 after it.
    task automatic step(input int which, input logic r, input logic sv, input logic [31:0] sd,
                        input logic mr, input logic fl);
        int sz, dep, cnt;
        logic pop_m, push_m, killed, dv, dr;
        logic [31:0] dd, front;
        @(negedge clk);
        rst = r;
        s_valid2 = 0; m_ready2 = 0; flush2 = 0; s_data2 = '0;
        s_valid4 = 0; m_ready4 = 0; flush4 = 0; s_data4 = '0;
        if (which == 2) begin
            s_valid2 = sv; s_data2 = sd; m_ready2 = mr; flush2 = fl;
            sz = q2.size(); dep = 2; dv = m_valid2; dd = m_data2;
        end else begin
            s_valid4 = sv; s_data4 = sd; m_ready4 = mr; flush4 = fl;
            sz = q4.size(); dep = 4; dv = m_valid4; dd = m_data4;
        end
        killed = r || (FLUSH_EN && fl);
        pop_m  = mr && sz > 0 && !killed;
        push_m = sv && sz < dep && !killed;
        if (mr && dv && !killed) begin
            if (sz == 0) chk("sb_pop_empty", dv, 0);
            else begin
                front = (which == 2) ? q2[0] : q4[0];
                chk("sb_pop_data", dd, front);
                if (which == 2) begin out2.push_back(dd); pops2++; end
            end
        end
        @(posedge clk);
        if (r) begin
            q2.delete(); q4.delete();
        end else if (killed) begin
            if (which == 2) q2.delete(); else q4.delete();
        end else begin
            if (which == 2) begin
                if (pop_m) void'(q2.pop_front());
                if (push_m) q2.push_back(sd);
            end else begin
                if (pop_m) void'(q4.pop_front());
                if (push_m) q4.push_back(sd);
            end
        end
        #1;
        if (which == 2) begin
            sz = q2.size(); cnt = int'(count2); dv = m_valid2; dr = s_ready2; dd = m_data2;
            if (sz > 0) front = q2[0];
        end else begin
            sz = q4.size(); cnt = int'(count4); dv = m_valid4; dr = s_ready4; dd = m_data4;
            if (sz > 0) front = q4[0];
        end
        chk("count", cnt, sz);
        chk("m_valid", dv, sz != 0);
        chk("s_ready", dr, sz != dep);
        if (sz > 0) chk("m_data_head", dd, front);
    endtask

    initial begin
        vt[0] = '{1'b1, 32'd1, 1'b0, 1, 32'd1};
        vt[1] = '{1'b1, 32'd2, 1'b0, 2, 32'd1};
        vt[2] = '{1'b1, 32'd3, 1'b0, 3, 32'd1};
        vt[3] = '{1'b1, 32'd4, 1'b0, 4, 32'd1};
        vt[4] = '{1'b1, 32'd5, 1'b0, 4, 32'd1};
        vt[5] = '{1'b0, 32'd0, 1'b1, 3, 32'd2};
        vt[6] = '{1'b0, 32'd0, 1'b1, 2, 32'd3};
        vt[7] = '{1'b0, 32'd0, 1'b1, 1, 32'd4};
        vt[8] = '{1'b0, 32'd0, 1'b1, 0, 32'd0};
        vt[9] = '{1'b0, 32'hFF, 1'b1, 0, 32'd0};

        // Reset held two cycles
        step(2, 1, 0, 0, 0, 0);
        step(2, 1, 0, 0, 0, 0);
        chk("rst_m_data2", m_data2, 0);
        chk("rst_m_data4", m_data4, 0);
        chk("rst_s_ready2", s_ready2, 1);
        chk("rst_count2", count2, 0);

        // Single transfer held under stall
        step(2, 0, 1, 32'hDEADBEEF, 0, 0);
        chk("single_count", count2, 1);
        chk("single_data", m_data2, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            step(2, 0, 0, 32'h12345678, 0, 0);
            chk("stall_data", m_data2, 32'hDEADBEEF);
            chk("stall_valid", m_valid2, 1);
        end
        step(2, 0, 0, 0, 1, 0);
        chk("single_drain", count2, 0);

        // Full with simultaneous pop: push refused that cycle
        out2.delete();
        step(2, 0, 1, 32'hA, 0, 0);
        step(2, 0, 1, 32'hB, 0, 0);
        chk("full_s_ready", s_ready2, 0);
        step(2, 0, 1, 32'hC, 1, 0);
        chk("fullpop_count", count2, 1);
        chk("fullpop_head", m_data2, 32'hB);
        chk("fullpop_s_ready", s_ready2, 1);
        step(2, 0, 1, 32'hC, 0, 0);
        chk("c_accept_count", count2, 2);
        step(2, 0, 0, 0, 1, 0);
        step(2, 0, 0, 0, 1, 0);
        chk("order_len", out2.size(), 3);
        if (out2.size() == 3) begin
            chk("order_0", out2[0], 32'hA);
            chk("order_1", out2[1], 32'hB);
            chk("order_2", out2[2], 32'hC);
        end

        // Streaming through DEPTH=2 with pointer wrap
        out2.delete();
        pops2 = 0;
        for (int i = 0; i < 100; i++) step(2, 0, 1, i, 1, 0);
        step(2, 0, 0, 0, 1, 0);
        chk("stream_pops", pops2, 100);
        if (out2.size() == 100) chk("stream_last", out2[99], 99);

        // Table-driven fill/drain of DEPTH=4
        for (int i = 0; i < 10; i++) begin
            step(4, 0, vt[i].sv, vt[i].sd, vt[i].mr, 0);
            chk($sformatf("vec%0d_count", i), count4, vt[i].exp_count);
            if (vt[i].exp_count > 0) chk($sformatf("vec%0d_head", i), m_data4, vt[i].exp_head);
        end

        // Flush with coincident push at count=3
        for (int i = 0; i < 3; i++) step(4, 0, 1, 32'h70 + i, 0, 0);
        step(4, 0, 1, 32'h77, 0, 1);
`ifdef PIPE_STAGE_FLUSH_EN
        chk("flush_count", count4, 0);
        chk("flush_m_valid", m_valid4, 0);
`else
        chk("noflush_count", count4, 4);
`endif
        step(4, 1, 0, 0, 0, 0);
        chk("reset_after_flush", count4, 0);

        // Reset mid-operation beats push and pop
        step(4, 0, 1, 32'h91, 0, 0);
        step(4, 0, 1, 32'h92, 0, 0);
        step(4, 1, 1, 32'h99, 1, 0);
        chk("midrst_count", count4, 0);
        chk("midrst_m_data", m_data4, 0);
        step(4, 0, 1, 32'h55, 0, 0);
        chk("post_rst_push", m_data4, 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
